// File: rtl/imem_fetch_arbiter_if.sv
// Fetch-side and shared-memory-side signals of the instruction fetch arbiter.
interface imem_fetch_arbiter_if #(
    parameter int unsigned NUM_CORES = 4
);
    localparam int unsigned DW = 32;

    logic [NUM_CORES-1:0]         fetch_req_valid;
    logic [NUM_CORES-1:0][DW-1:0] fetch_pc;
    logic [NUM_CORES-1:0]         fetch_rsp_valid;
    logic [NUM_CORES-1:0][DW-1:0] fetch_rsp_instr;
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [DW-1:0]                mem_req_addr;
    logic                         mem_rsp_valid;
    logic [DW-1:0]                mem_rsp_data;

    // Cores and instruction memory side
    modport master (
        output fetch_req_valid, fetch_pc,
        input  fetch_rsp_valid, fetch_rsp_instr,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    // Arbiter side
    modport slave (
        input  fetch_req_valid, fetch_pc,
        output fetch_rsp_valid, fetch_rsp_instr,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Shares one instruction memory port among NUM_CORES cores, with a one-entry
// instruction buffer per core and round-robin grant of misses.
module imem_fetch_arbiter #(
    parameter int unsigned NUM_CORES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  busy,
    imem_fetch_arbiter_if.slave   bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;

    logic [NUM_CORES-1:0]         bv;
    logic [NUM_CORES-1:0][AW-1:0] btag;
    logic [NUM_CORES-1:0][AW-1:0] bdata;

    logic [GW-1:0]                gid;
    logic [GW-1:0]                last_grant;
    logic [AW-1:0]                gpc;
    logic                         kill;

    logic [NUM_CORES-1:0]         rsp_valid;
    logic [NUM_CORES-1:0][AW-1:0] rsp_instr;
    logic                         mem_req_valid_q;
    logic [AW-1:0]                mem_req_addr_q;
    logic                         busy_q;

    logic [NUM_CORES-1:0]         active_c;
    logic [NUM_CORES-1:0]         hit_c;
    logic [NUM_CORES-1:0]         miss_c;
    logic                         grant_found_c;
    logic [GW-1:0]                grant_id_c;
    logic                         grant_c;
    logic                         done_c;
    logic                         buf_wr_c;
    logic                         mem_req_valid_nxt;
    logic                         busy_nxt;

    // Classify each core's request as hit or miss against its buffer entry
    always_comb begin
        active_c = '0;
        hit_c    = '0;
        miss_c   = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            active_c[i] = bus.fetch_req_valid[i] && !rsp_valid[i] &&
                          !((state != S_IDLE) && (gid == GW'(i)));
            hit_c[i]    = active_c[i] && bv[i] && (btag[i] == bus.fetch_pc[i]);
            miss_c[i]   = active_c[i] && !hit_c[i];
        end
    end

    // Round-robin pick of the first missing core after last_grant
    always_comb begin
        int idx;
        grant_found_c = 1'b0;
        grant_id_c    = '0;
        idx           = 0;
        for (int k = 1; k <= int'(NUM_CORES); k++) begin
            idx = int'(last_grant) + k;
            if (idx >= int'(NUM_CORES)) begin
                idx = idx - int'(NUM_CORES);
            end
            if (!grant_found_c && miss_c[GW'(idx)]) begin
                grant_found_c = 1'b1;
                grant_id_c    = GW'(idx);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found_c)     state_nxt = S_REQ;
            S_REQ:   if (bus.mem_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (bus.mem_rsp_valid) state_nxt = S_IDLE;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: grant/complete strobes and next values of registered outputs
    always_comb begin
        grant_c           = 1'b0;
        done_c            = 1'b0;
        buf_wr_c          = 1'b0;
        mem_req_valid_nxt = 1'b0;
        busy_nxt          = 1'b0;
        grant_c           = (state == S_IDLE) && grant_found_c;
        done_c            = (state == S_WAIT) && bus.mem_rsp_valid;
        // A flush arriving with the data also keeps the word out of the buffer
        buf_wr_c          = done_c && !kill && !flush;
        mem_req_valid_nxt = (state_nxt == S_REQ);
        busy_nxt          = (state_nxt != S_IDLE);
    end

    // Grant bookkeeping, kill flag and registered memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gid             <= '0;
            gpc             <= '0;
            last_grant      <= GW'(NUM_CORES - 1);
            kill            <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            busy_q          <= 1'b0;
        end else begin
            mem_req_valid_q <= mem_req_valid_nxt;
            busy_q          <= busy_nxt;
            if (grant_c) begin
                gid            <= grant_id_c;
                gpc            <= bus.fetch_pc[grant_id_c];
                last_grant     <= grant_id_c;
                kill           <= 1'b0;
                mem_req_addr_q <= bus.fetch_pc[grant_id_c];
            end else if (flush && (state != S_IDLE)) begin
                kill <= 1'b1;
            end
        end
    end

    // Per-core response pulses and buffer fill/invalidate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bv        <= '0;
            btag      <= '0;
            bdata     <= '0;
            rsp_valid <= '0;
            rsp_instr <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                rsp_valid[i] <= hit_c[i] || (done_c && (gid == GW'(i)));
                if (hit_c[i]) begin
                    rsp_instr[i] <= bdata[i];
                end else if (done_c && (gid == GW'(i))) begin
                    rsp_instr[i] <= bus.mem_rsp_data;
                end
                if (flush) begin
                    bv[i] <= 1'b0;
                end else if (buf_wr_c && (gid == GW'(i))) begin
                    bv[i]    <= 1'b1;
                    btag[i]  <= gpc;
                    bdata[i] <= bus.mem_rsp_data;
                end
            end
        end
    end

    assign bus.fetch_rsp_valid = rsp_valid;
    assign bus.fetch_rsp_instr = rsp_instr;
    assign bus.mem_req_valid   = mem_req_valid_q;
    assign bus.mem_req_addr    = mem_req_addr_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: cycle table plus corner-case sequences.
module tb_imem_fetch_arbiter;
    localparam int NC = 4;
    localparam int NV = 18;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] pc0;
        logic        rdy;
        logic        mrv;
        logic [31:0] mdata;
        logic [3:0]  e_rsp;
        logic [31:0] e_instr0;
        logic        e_mrv;
        logic [31:0] e_addr;
        logic        e_busy;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              busy;
    logic [3:0]        req;
    logic [3:0][31:0]  pc;
    logic              mem_auto;
    logic              t_rdy;
    logic              t_rv;
    logic [31:0]       t_data;
    logic              m_rdy;
    logic              m_rv;
    logic [31:0]       m_data;
    logic              m_pend;
    logic [31:0]       m_addr;
    int                m_dly;
    int                m_lat;
    logic [31:0]       grant_q[$];
    int                rsp_cnt[NC];
    logic [31:0]       rsp_last[NC];
    int                n_checks;
    int                n_errors;
    vec_t              vecs[NV];

    imem_fetch_arbiter_if #(.NUM_CORES(NC)) bus ();

    assign bus.fetch_req_valid = req;
    assign bus.fetch_pc        = pc;
    assign bus.mem_req_ready   = mem_auto ? m_rdy  : t_rdy;
    assign bus.mem_rsp_valid   = mem_auto ? m_rv   : t_rv;
    assign bus.mem_rsp_data    = mem_auto ? m_data : t_data;

    imem_fetch_arbiter #(.NUM_CORES(NC)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    // Memory model: accepts on ready, returns data m_lat cycles after the first WAIT cycle
    initial begin
        m_rv = 1'b0; m_data = '0; m_pend = 1'b0; m_addr = '0; m_dly = 0;
        forever begin
            @(negedge clk);
            m_rv = 1'b0;
            if (!rst) begin
                m_pend = 1'b0;
            end else begin
                if (m_pend) begin
                    if (m_dly == 0) begin
                        m_rv = 1'b1; m_data = mem_word(m_addr); m_pend = 1'b0;
                    end else begin
                        m_dly--;
                    end
                end
                if (mem_auto && bus.mem_req_valid && m_rdy) begin
                    m_pend = 1'b1; m_addr = bus.mem_req_addr; m_dly = m_lat;
                    grant_q.push_back(bus.mem_req_addr);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; record responses and drop the request of any core that was answered
    task automatic cyc();
        @(posedge clk); #1;
        for (int i = 0; i < NC; i++) begin
            if (bus.fetch_rsp_valid[i]) begin
                rsp_cnt[i]++;
                rsp_last[i] = bus.fetch_rsp_instr[i];
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_rsp(input int core, input logic [31:0] exp, input string name);
        int c0;
        int n;
        c0 = rsp_cnt[core];
        n  = 0;
        while (rsp_cnt[core] == c0 && n < 60) begin
            cyc();
            n++;
        end
        check({name, "_seen"}, 32'(rsp_cnt[core] != c0), 32'd1);
        check({name, "_data"}, rsp_last[core], exp);
        cyc();
    endtask

    task automatic wait_all(input string name);
        int c0[NC];
        int n;
        logic done;
        for (int i = 0; i < NC; i++) c0[i] = rsp_cnt[i];
        n = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            cyc();
            n++;
            done = 1'b1;
            for (int i = 0; i < NC; i++) if (rsp_cnt[i] == c0[i]) done = 1'b0;
        end
        check(name, 32'(done), 32'd1);
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; flush = 1'b0;
        t_rdy = 1'b0; t_rv = 1'b0; t_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] p, input logic rd,
                                input logic mv, input logic [31:0] md, input logic [3:0] ers,
                                input logic [31:0] ei, input logic emv, input logic [31:0] ea,
                                input logic eb);
        vec_t v;
        v.req = r; v.pc0 = p; v.rdy = rd; v.mrv = mv; v.mdata = md;
        v.e_rsp = ers; v.e_instr0 = ei; v.e_mrv = emv; v.e_addr = ea; v.e_busy = eb;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_order[4];
        n_checks = 0; n_errors = 0;
        rst = 1'b0; req = '0; pc = '0; flush = 1'b0;
        mem_auto = 1'b0; m_rdy = 1'b1; m_lat = 0;
        t_rdy = 1'b0; t_rv = 1'b0; t_data = '0;
        for (int i = 0; i < NC; i++) begin rsp_cnt[i] = 0; rsp_last[i] = '0; end

        //              req   pc0          rdy mrv data          e_rsp e_instr0      e_mrv e_addr  busy
        vecs[0]  = mk(4'h1, 32'h100, 1, 0, 32'h0,         4'h0, 32'h0,         1, 32'h100, 1);
        vecs[1]  = mk(4'h1, 32'h100, 1, 0, 32'h0,         4'h0, 32'h0,         0, 32'h100, 1);
        vecs[2]  = mk(4'h1, 32'h100, 1, 1, 32'hDEADBEEF,  4'h1, 32'hDEADBEEF,  0, 32'h100, 0);
        vecs[3]  = mk(4'h1, 32'h100, 1, 0, 32'h0,         4'h0, 32'hDEADBEEF,  0, 32'h100, 0);
        vecs[4]  = mk(4'h1, 32'h100, 1, 0, 32'h0,         4'h1, 32'hDEADBEEF,  0, 32'h100, 0);
        vecs[5]  = mk(4'h1, 32'h104, 1, 0, 32'h0,         4'h0, 32'hDEADBEEF,  0, 32'h100, 0);
        vecs[6]  = mk(4'h1, 32'h104, 1, 0, 32'h0,         4'h0, 32'hDEADBEEF,  1, 32'h104, 1);
        vecs[7]  = mk(4'h1, 32'h104, 0, 0, 32'h0,         4'h0, 32'hDEADBEEF,  1, 32'h104, 1);
        vecs[8]  = mk(4'h1, 32'h104, 1, 0, 32'h0,         4'h0, 32'hDEADBEEF,  0, 32'h104, 1);
        vecs[9]  = mk(4'h1, 32'h104, 1, 0, 32'h0,         4'h0, 32'hDEADBEEF,  0, 32'h104, 1);
        vecs[10] = mk(4'h1, 32'h104, 1, 1, 32'h12345678,  4'h1, 32'h12345678,  0, 32'h104, 0);
        vecs[11] = mk(4'h0, 32'h104, 1, 0, 32'h0,         4'h0, 32'h12345678,  0, 32'h104, 0);
        vecs[12] = mk(4'h1, 32'h104, 1, 0, 32'h0,         4'h1, 32'h12345678,  0, 32'h104, 0);
        vecs[13] = mk(4'h1, 32'h100, 1, 0, 32'h0,         4'h0, 32'h12345678,  0, 32'h104, 0);
        vecs[14] = mk(4'h1, 32'h100, 1, 0, 32'h0,         4'h0, 32'h12345678,  1, 32'h100, 1);
        vecs[15] = mk(4'h1, 32'h100, 1, 0, 32'h0,         4'h0, 32'h12345678,  0, 32'h100, 1);
        vecs[16] = mk(4'h1, 32'h100, 1, 1, 32'hDEADBEEF,  4'h1, 32'hDEADBEEF,  0, 32'h100, 0);
        vecs[17] = mk(4'h0, 32'h100, 1, 1, 32'h00000BAD,  4'h0, 32'hDEADBEEF,  0, 32'h100, 0);

        // Reset values
        do_reset();
        check("rst_rsp_valid", 32'(bus.fetch_rsp_valid), 32'h0);
        check("rst_rsp_instr0", bus.fetch_rsp_instr[0], 32'h0);
        check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
        check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Cycle table: first miss, hit, consumed rule, stalled accept, replacement
        for (int v = 0; v < NV; v++) begin
            req = vecs[v].req; pc[0] = vecs[v].pc0;
            t_rdy = vecs[v].rdy; t_rv = vecs[v].mrv; t_data = vecs[v].mdata;
            @(posedge clk); #1;
            check($sformatf("v%0d_rsp_valid", v), 32'(bus.fetch_rsp_valid), 32'(vecs[v].e_rsp));
            check($sformatf("v%0d_rsp_instr0", v), bus.fetch_rsp_instr[0], vecs[v].e_instr0);
            check($sformatf("v%0d_mem_req_valid", v), 32'(bus.mem_req_valid), 32'(vecs[v].e_mrv));
            check($sformatf("v%0d_mem_req_addr", v), bus.mem_req_addr, vecs[v].e_addr);
            check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
        end

        // Round robin from reset: order 0,1,2,3
        do_reset();
        mem_auto = 1'b1; m_rdy = 1'b1; m_lat = 0;
        grant_q.delete();
        pc[0] = 32'h00; pc[1] = 32'h10; pc[2] = 32'h20; pc[3] = 32'h30;
        req = 4'hF;
        wait_all("rr1_done");
        exp_order[0] = 32'h00; exp_order[1] = 32'h10; exp_order[2] = 32'h20; exp_order[3] = 32'h30;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("rr1_grant%0d", j), (j < grant_q.size()) ? grant_q[j] : 32'hFFFF_FFFF,
                  exp_order[j]);
            check($sformatf("rr1_data%0d", j), rsp_last[j], mem_word(exp_order[j]));
        end

        // All four cores hit in the same cycle
        req = 4'hF;
        cyc();
        check("multi_hit_valid", 32'(bus.fetch_rsp_valid), 32'hF);
        for (int j = 0; j < 4; j++)
            check($sformatf("multi_hit_instr%0d", j), bus.fetch_rsp_instr[j], mem_word(exp_order[j]));
        check("multi_hit_no_mem", 32'(bus.mem_req_valid), 32'h0);
        cyc();

        // Grant core 1 alone, then all four miss: order starts at core 2
        pc[1] = 32'h50; req[1] = 1'b1;
        wait_rsp(1, mem_word(32'h50), "rr_core1");
        grant_q.delete();
        pc[0] = 32'h1000; pc[1] = 32'h1010; pc[2] = 32'h1020; pc[3] = 32'h1030;
        req = 4'hF;
        wait_all("rr2_done");
        exp_order[0] = 32'h1020; exp_order[1] = 32'h1030; exp_order[2] = 32'h1000; exp_order[3] = 32'h1010;
        for (int j = 0; j < 4; j++)
            check($sformatf("rr2_grant%0d", j), (j < grant_q.size()) ? grant_q[j] : 32'hFFFF_FFFF,
                  exp_order[j]);

        // Stalled memory: request held stable, core 1 still hits in one cycle
        m_rdy = 1'b0;
        pc[0] = 32'h2000; req[0] = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_valid%0d", k), 32'(bus.mem_req_valid), 32'h1);
            check($sformatf("stall_addr%0d", k), bus.mem_req_addr, 32'h2000);
            if (k == 2) begin
                check("stall_hit_valid", 32'(bus.fetch_rsp_valid[1]), 32'h1);
                check("stall_hit_instr", bus.fetch_rsp_instr[1], mem_word(32'h1010));
            end
            if (k == 1) begin
                pc[1] = 32'h1010; req[1] = 1'b1;
            end
            cyc();
        end
        m_rdy = 1'b1;
        wait_rsp(0, mem_word(32'h2000), "stall_miss");

        // Flush while core 2's miss is in WAIT
        m_lat = 3;
        pc[2] = 32'h200; req[2] = 1'b1;
        begin
            int n;
            n = 0;
            cyc();
            while (!(busy && !bus.mem_req_valid) && n < 20) begin
                cyc();
                n++;
            end
        end
        check("flush_in_wait", 32'(busy && !bus.mem_req_valid), 32'h1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_rsp(2, mem_word(32'h200), "flush_delivered");
        m_lat = 0;
        pc[2] = 32'h200; req[2] = 1'b1;
        cyc();
        check("flush_core2_no_hit", 32'(bus.fetch_rsp_valid[2]), 32'h0);
        check("flush_core2_remiss", 32'(bus.mem_req_valid), 32'h1);
        check("flush_core2_addr", bus.mem_req_addr, 32'h200);
        wait_rsp(2, mem_word(32'h200), "flush_core2_refetch");
        pc[1] = 32'h1010; req[1] = 1'b1;
        cyc();
        check("flush_core1_no_hit", 32'(bus.fetch_rsp_valid[1]), 32'h0);
        check("flush_core1_remiss", 32'(bus.mem_req_valid), 32'h1);
        check("flush_core1_addr", bus.mem_req_addr, 32'h1010);
        wait_rsp(1, mem_word(32'h1010), "flush_core1_refetch");

        // Asynchronous reset while in REQ, then a stray memory response
        m_rdy = 1'b0;
        pc[3] = 32'h300; req[3] = 1'b1;
        cyc();
        check("arst_pre_valid", 32'(bus.mem_req_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_rdy = 1'b1;
        mem_auto = 1'b0;
        t_rv = 1'b1; t_data = 32'h0000_0BAD;
        cyc();
        t_rv = 1'b0;
        check("stray_rsp_valid0", 32'(bus.fetch_rsp_valid), 32'h0);
        check("stray_busy0", 32'(busy), 32'h0);
        cyc();
        check("stray_rsp_valid1", 32'(bus.fetch_rsp_valid), 32'h0);
        check("stray_mem_req_valid", 32'(bus.mem_req_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
